// File: rtl/gate_bist_pkg.sv
// Shared types and golden model for the gate_bist BIST sequencer.
package gate_bist_pkg;

    localparam int GATE_W = 7;

    localparam int AND_IDX  = 0;
    localparam int OR_IDX   = 1;
    localparam int NOT_IDX  = 2;
    localparam int NAND_IDX = 3;
    localparam int NOR_IDX  = 4;
    localparam int XOR_IDX  = 5;
    localparam int XNOR_IDX = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [GATE_W-1:0] golden(input logic a, input logic b);
        logic [GATE_W-1:0] g;
        g           = '0;
        g[AND_IDX]  = a & b;
        g[OR_IDX]   = a | b;
        g[NOT_IDX]  = ~a;
        g[NAND_IDX] = ~(a & b);
        g[NOR_IDX]  = ~(a | b);
        g[XOR_IDX]  = a ^ b;
        g[XNOR_IDX] = ~(a ^ b);
        return g;
    endfunction

endpackage

// File: rtl/gate_bist_cmp.sv
// Combinational golden-vs-sampled comparator for the gate unit outputs.
module gate_bist_cmp
    import gate_bist_pkg::*;
(
    input  logic              a,
    input  logic              b,
    input  logic [GATE_W-1:0] gate_out,
    output logic              mismatch,
    output logic [GATE_W-1:0] mask
);

    logic [GATE_W-1:0] expected;

    assign expected = golden(a, b);
    assign mask     = expected ^ gate_out;
    // Case inequality so an X/Z on any gate output is reported as a failure.
    assign mismatch = (gate_out !== expected);

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer for the two-input gate unit: sweeps {a,b}, checks, counts errors.
// Define GATE_BIST_ERRLOG_EN to add the first-failure log (fail_vec/fail_mask/fail_valid).
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int PASSES        = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              a,
    output logic              b,
    input  logic [GATE_W-1:0] gate_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
`ifdef GATE_BIST_ERRLOG_EN
    output logic [1:0]        fail_vec,
    output logic [GATE_W-1:0] fail_mask,
    output logic              fail_valid,
`endif
    output logic [7:0]        err_cnt
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

    state_t            state;
    logic [1:0]        vec_idx;
    logic [PW-1:0]     pass_idx;
    logic [SW-1:0]     settle_cnt;
    logic              mismatch;
    logic [GATE_W-1:0] cmp_mask;
    logic              last_settle;
    logic              last_pass;

    gate_bist_cmp u_cmp (
        .a        (a),
        .b        (b),
        .gate_out (gate_out),
        .mismatch (mismatch),
        .mask     (cmp_mask)
    );

`ifndef GATE_BIST_ERRLOG_EN
    logic unused_mask;
    assign unused_mask = ^cmp_mask;
`endif

    assign last_settle = (settle_cnt == SW'(SETTLE_CYCLES - 1));
    assign last_pass   = (pass_idx == PW'(PASSES - 1));

    // NOTE: all state and outputs update with non-blocking assignments so every
    // branch reads the pre-edge values; blocking here would create order races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            vec_idx    <= '0;
            pass_idx   <= '0;
            settle_cnt <= '0;
            a          <= 1'b0;
            b          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
`ifdef GATE_BIST_ERRLOG_EN
            fail_vec   <= '0;
            fail_mask  <= '0;
            fail_valid <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    a    <= 1'b0;
                    b    <= 1'b0;
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        state      <= ST_APPLY;
                        busy       <= 1'b1;
                        vec_idx    <= '0;
                        pass_idx   <= '0;
                        settle_cnt <= '0;
                        err_cnt    <= '0;
                        pass       <= 1'b0;
`ifdef GATE_BIST_ERRLOG_EN
                        fail_vec   <= '0;
                        fail_mask  <= '0;
                        fail_valid <= 1'b0;
`endif
                    end
                end

                ST_APPLY: begin
                    if (last_settle) begin
                        state <= ST_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end

                ST_CHECK: begin
                    if (mismatch) begin
                        if (err_cnt != 8'hff) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
`ifdef GATE_BIST_ERRLOG_EN
                        if (!fail_valid) begin
                            fail_vec   <= {a, b};
                            fail_mask  <= cmp_mask;
                            fail_valid <= 1'b1;
                        end
`endif
                    end
                    settle_cnt <= '0;
                    if (vec_idx == 2'd3 && last_pass) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        // Fold in this final check so pass is valid in the done cycle.
                        pass  <= (err_cnt == 8'd0) && !mismatch;
                    end else if (vec_idx == 2'd3) begin
                        state    <= ST_APPLY;
                        pass_idx <= pass_idx + PW'(1);
                        vec_idx  <= '0;
                        {a, b}   <= 2'b00;
                    end else begin
                        state   <= ST_APPLY;
                        vec_idx <= vec_idx + 2'd1;
                        {a, b}  <= vec_idx + 2'd1;
                    end
                end

                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed self-checking bench for gate_bist_ctrl (default and 3-pass/2-settle instances).
module tb_gate_bist_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic start0, start1;
    int   mode0, mode1;
    int   n_vec = 0;
    int   n_err = 0;

    logic       a0, b0, busy0, done0, pass0;
    logic [7:0] err0;
    logic [6:0] gout0;
    logic       a1, b1, busy1, done1, pass1;
    logic [7:0] err1;
    logic [6:0] gout1;
`ifdef GATE_BIST_ERRLOG_EN
    logic [1:0] fvec0, fvec1;
    logic [6:0] fmask0, fmask1;
    logic       fval0, fval1;
`endif

    always #5 clk = ~clk;

    // Behavioural gate unit with optional planted faults.
    function automatic logic [6:0] dataflow(input logic a, input logic b, input int mode);
        logic [6:0] g;
        g = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
        if (mode == 1) g = g | 7'b0000001;
        if (mode == 2) g = 7'h7f;
        return g;
    endfunction

    assign gout0 = dataflow(a0, b0, mode0);
    assign gout1 = dataflow(a1, b1, mode1);

    gate_bist_ctrl u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .gate_out(gout0),
        .busy(busy0), .done(done0), .pass(pass0),
`ifdef GATE_BIST_ERRLOG_EN
        .fail_vec(fvec0), .fail_mask(fmask0), .fail_valid(fval0),
`endif
        .err_cnt(err0)
    );

    gate_bist_ctrl #(.SETTLE_CYCLES(2), .PASSES(3)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .gate_out(gout1),
        .busy(busy1), .done(done1), .pass(pass1),
`ifdef GATE_BIST_ERRLOG_EN
        .fail_vec(fvec1), .fail_mask(fmask1), .fail_valid(fval1),
`endif
        .err_cnt(err1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int dones;
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        mode0  = 0;
        mode1  = 0;
        #12;

        check("rst_ab",    {30'd0, a0, b0}, 0);
        check("rst_busy",  {31'd0, busy0}, 0);
        check("rst_done",  {31'd0, done0}, 0);
        check("rst_pass",  {31'd0, pass0}, 0);
        check("rst_err",   {24'd0, err0}, 0);
        check("rst_u1",    {28'd0, a1, b1, busy1, done1}, 0);
`ifdef GATE_BIST_ERRLOG_EN
        check("rst_flog",  {22'd0, fvec0, fmask0, fval0}, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Good unit, defaults: vectors 00,00,01,01,10,10,11,11 then done at edge k+9.
        tick();
        start0 = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 1) start0 = 1'b0;
            if (i <= 8) begin
                check($sformatf("ab_seq_%0d", i), {30'd0, a0, b0}, (i - 1) / 2);
                check($sformatf("busy_%0d", i), {31'd0, busy0}, 1);
                check($sformatf("nodone_%0d", i), {31'd0, done0}, 0);
            end
        end
        check("good_done", {31'd0, done0}, 1);
        check("good_pass", {31'd0, pass0}, 1);
        check("good_err",  {24'd0, err0}, 0);
        tick();
        check("good_done_fall", {31'd0, done0}, 0);
        check("good_busy_fall", {31'd0, busy0}, 0);
        check("good_pass_hold", {31'd0, pass0}, 1);

        // AND stuck-at-1: vectors 00,01,10 fail.
        mode0 = 1;
        tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (8) tick();
        check("and_sa1_done", {31'd0, done0}, 1);
        check("and_sa1_err",  {24'd0, err0}, 3);
        check("and_sa1_pass", {31'd0, pass0}, 0);
`ifdef GATE_BIST_ERRLOG_EN
        check("and_sa1_fvec",  {30'd0, fvec0}, 0);
        check("and_sa1_fmask", {25'd0, fmask0}, 7'b0000001);
        check("and_sa1_fval",  {31'd0, fval0}, 1);
`endif
        mode0 = 0;

        // PASSES=3, SETTLE_CYCLES=2: done at edge k+37.
        tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (35) tick();
        check("p3_nodone_36", {31'd0, done1}, 0);
        tick();
        check("p3_done_37", {31'd0, done1}, 1);
        check("p3_err",     {24'd0, err1}, 0);
        check("p3_pass",    {31'd0, pass1}, 1);
        mode1 = 2;
        repeat (2) tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (36) tick();
        check("p3_ones_done", {31'd0, done1}, 1);
        check("p3_ones_err",  {24'd0, err1}, 12);
        check("p3_ones_pass", {31'd0, pass1}, 0);
        mode1 = 0;

        // Reset during CHECK of vector 10.
        tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (5) tick();
        check("mid_ab_10", {30'd0, a0, b0}, 2'b10);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ab",   {30'd0, a0, b0}, 0);
        check("mid_rst_busy", {31'd0, busy0}, 0);
        check("mid_rst_done", {31'd0, done0}, 0);
        check("mid_rst_err",  {24'd0, err0}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done0) dones++;
        end
        check("mid_rst_no_done", dones, 0);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (8) tick();
        check("post_rst_done", {31'd0, done0}, 1);
        check("post_rst_pass", {31'd0, pass0}, 1);

        // start held high: done every 10 cycles.
        repeat (3) tick();
        start0 = 1'b1;
        repeat (9) tick();
        check("held_done_9", {31'd0, done0}, 1);
        repeat (9) tick();
        check("held_nodone_18", {31'd0, done0}, 0);
        tick();
        check("held_done_19", {31'd0, done0}, 1);
        repeat (10) tick();
        check("held_done_29", {31'd0, done0}, 1);
        start0 = 1'b0;
        for (int i = 0; i < 20 && busy0; i++) tick();
        check("held_stop_busy", {31'd0, busy0}, 0);

        // start pulse during busy is ignored.
        tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (2) tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (5) tick();
        check("ign_done_9", {31'd0, done0}, 1);
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done0) dones++;
        end
        check("ign_no_rerun", dones, 0);
        check("ign_idle_busy", {31'd0, busy0}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
